// File: rtl/clause_index_sequencer.sv
// -----------------------------------------------------------------------------
// clause_index_sequencer
//
// Purpose:
//   Generates the (class, clause, patch) index stream for the clause datapath
//   and clause_class_compare. For each class, for each clause, every
//   convolution patch is walked. Class and clause stay constant across the
//   patches of one clause, so the downstream comparator sees a run of equal
//   indices and a change at each boundary. One full sweep runs per start.
//   A done pulse is sent to the inference controller at the end.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   start        in   begin one sweep; only sampled while idle
//   ready        in   downstream accepts the current beat when valid & ready
//   valid        out  class_out/clause_out/patch_out hold a live beat
//   class_out    out  current class index
//   clause_out   out  current clause index
//   patch_out    out  current patch index
//   last_patch   out  live beat is patch NUM_PATCHES-1
//   last_clause  out  last_patch and clause NUM_CLAUSES-1
//   last_class   out  last_clause and class NUM_CLASSES-1 (final beat)
//   busy         out  sweep in progress (RUN or DONE)
//   done         out  one-cycle pulse after the final beat is accepted
//
// All outputs are registered. There is no combinational path from start or
// ready to any output.
// -----------------------------------------------------------------------------
module clause_index_sequencer #(
    parameter int NUM_CLASSES = 10,
    parameter int NUM_CLAUSES = 512,
    parameter int NUM_PATCHES = 361,
    parameter int CLASS_W     = 4,
    parameter int CLAUSE_W    = 9,
    parameter int PATCH_W     = 9
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                ready,
    output logic                valid,
    output logic [CLASS_W-1:0]  class_out,
    output logic [CLAUSE_W-1:0] clause_out,
    output logic [PATCH_W-1:0]  patch_out,
    output logic                last_patch,
    output logic                last_clause,
    output logic                last_class,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Terminal counts. They are compared against the full index width, so an
    // index can never step past its terminal value into an unused code.
    localparam logic [CLASS_W-1:0]  CLASS_MAX  = CLASS_W'(NUM_CLASSES - 1);
    localparam logic [CLAUSE_W-1:0] CLAUSE_MAX = CLAUSE_W'(NUM_CLAUSES - 1);
    localparam logic [PATCH_W-1:0]  PATCH_MAX  = PATCH_W'(NUM_PATCHES - 1);

    state_t              state_q, state_d;
    logic                valid_d;
    logic                busy_d;
    logic                done_d;
    logic [CLASS_W-1:0]  class_d;
    logic [CLAUSE_W-1:0] clause_d;
    logic [PATCH_W-1:0]  patch_d;
    logic                last_patch_d;
    logic                last_clause_d;
    logic                last_class_d;

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so that no
        // path through the case leaves a value unassigned and no latch is
        // inferred.
        state_d  = state_q;
        valid_d  = valid;
        busy_d   = busy;
        done_d   = 1'b0;
        class_d  = class_out;
        clause_d = clause_out;
        patch_d  = patch_out;

        case (state_q)
            S_IDLE: begin
                valid_d  = 1'b0;
                busy_d   = 1'b0;
                class_d  = '0;
                clause_d = '0;
                patch_d  = '0;
                if (start) begin
                    // The first beat (0,0,0) is live on the same edge that
                    // enters RUN.
                    state_d = S_RUN;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            S_RUN: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                // valid is always high in RUN, so ready alone marks an
                // accepted beat. Without ready, every output holds.
                if (ready) begin
                    if (last_class) begin
                        // Final beat accepted. Indices keep their final
                        // values for the DONE cycle.
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (patch_out == PATCH_MAX) begin
                        patch_d = '0;
                        if (clause_out == CLAUSE_MAX) begin
                            clause_d = '0;
                            class_d  = class_out + CLASS_W'(1);
                        end else begin
                            clause_d = clause_out + CLAUSE_W'(1);
                        end
                    end else begin
                        patch_d = patch_out + PATCH_W'(1);
                    end
                end
            end

            S_DONE: begin
                // One cycle only. start is ignored here.
                state_d  = S_IDLE;
                valid_d  = 1'b0;
                busy_d   = 1'b0;
                class_d  = '0;
                clause_d = '0;
                patch_d  = '0;
            end

            default: begin
                state_d  = S_IDLE;
                valid_d  = 1'b0;
                busy_d   = 1'b0;
                class_d  = '0;
                clause_d = '0;
                patch_d  = '0;
            end
        endcase

        // The last flags are decoded from the next-state indices and are
        // registered with them. Gating with valid_d keeps every flag low
        // whenever no beat is live.
        last_patch_d  = valid_d && (patch_d == PATCH_MAX);
        last_clause_d = last_patch_d && (clause_d == CLAUSE_MAX);
        last_class_d  = last_clause_d && (class_d == CLASS_MAX);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            valid       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            class_out   <= '0;
            clause_out  <= '0;
            patch_out   <= '0;
            last_patch  <= 1'b0;
            last_clause <= 1'b0;
            last_class  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here make all registers update
            // together from the values they held before the edge.
            state_q     <= state_d;
            valid       <= valid_d;
            busy        <= busy_d;
            done        <= done_d;
            class_out   <= class_d;
            clause_out  <= clause_d;
            patch_out   <= patch_d;
            last_patch  <= last_patch_d;
            last_clause <= last_clause_d;
            last_class  <= last_class_d;
        end
    end

endmodule
